// File: rtl/voter_timed.sv
// Timed N-voter judge: opens a window on start, latches sticky yes-votes,
// and publishes yes-count plus pass/fail with a one-cycle done pulse.
module voter_timed #(
  parameter int N      = 3,
  parameter int WINDOW = 16,
  parameter int THRESH = N/2 + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N-1:0]             vote,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [$clog2(N+1)-1:0]   yes_cnt,
  output logic [15:0]              time_left
);
  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_t;

  state_t        state;
  logic [15:0]   timer;
  logic [N-1:0]  latch;
  logic [N-1:0]  latch_next;
  logic [CW-1:0] pop;
  logic          all_yes;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_lane
      assign latch_next[g] = latch[g] | vote[g];
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + CW'(latch_next[i]);
  end

  assign all_yes = &latch_next;

  // Early close when every voter has voted; otherwise run the timer out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      latch   <= '0;
      pass    <= 1'b0;
      yes_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= COLLECT;
          timer   <= 16'(WINDOW - 1);
          latch   <= '0;
          pass    <= 1'b0;
          yes_cnt <= '0;
        end
        COLLECT: begin
          latch <= latch_next;
          if (timer == 16'd0 || all_yes) begin
            state   <= RESULT;
            timer   <= '0;
            yes_cnt <= pop;
            pass    <= (pop >= CW'(THRESH));
          end else begin
            timer <= timer - 16'd1;
          end
        end
        RESULT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == COLLECT);
  assign done      = (state == RESULT);
  assign time_left = busy ? timer : 16'd0;
endmodule

// File: tb/tb_voter_timed.sv
// Directed bench for voter_timed: 3-voter majority and 5-voter unanimous configs.
module tb_voter_timed;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start3, busy3, done3, pass3;
  logic [2:0]  vote3;
  logic [1:0]  yes3;
  logic [15:0] tl3;

  logic        start5, busy5, done5, pass5;
  logic [4:0]  vote5;
  logic [2:0]  yes5;
  logic [15:0] tl5;

  int total = 0;
  int bad   = 0;

  voter_timed #(.N(3), .WINDOW(8), .THRESH(2)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .vote(vote3), .busy(busy3),
    .done(done3), .pass(pass3), .yes_cnt(yes3), .time_left(tl3));

  voter_timed #(.N(5), .WINDOW(4), .THRESH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .vote(vote5), .busy(busy5),
    .done(done5), .pass(pass5), .yes_cnt(yes5), .time_left(tl5));

  // {busy,done,pass,yes_cnt,time_left}
  function automatic logic [20:0] e3(input logic b, d, p, input logic [1:0] y, input int t);
    return {b, d, p, y, 16'(t)};
  endfunction
  function automatic logic [21:0] e5(input logic b, d, p, input logic [2:0] y, input int t);
    return {b, d, p, y, 16'(t)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; start3 = 1; vote3 = '1; start5 = 1; vote5 = '1;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if ({busy3, done3, pass3, yes3, tl3} !== e3(0, 0, 0, 0, 0)) begin
        bad++; $display("FAIL reset3 cyc%0d got=%h exp=%h", c, {busy3, done3, pass3, yes3, tl3}, e3(0, 0, 0, 0, 0));
      end
      total++;
      if ({busy5, done5, pass5, yes5, tl5} !== e5(0, 0, 0, 0, 0)) begin
        bad++; $display("FAIL reset5 cyc%0d got=%h exp=%h", c, {busy5, done5, pass5, yes5, tl5}, e5(0, 0, 0, 0, 0));
      end
    end
    rst = 0; start3 = 0; vote3 = '0; start5 = 0; vote5 = '0;
    tick();
  endtask

  task automatic test_full_window();
    start3 = 1; vote3 = 3'b011;
    tick();
    start3 = 0;
    for (int c = 0; c < 8; c++) begin
      total++;
      if ({busy3, done3, pass3, yes3, tl3} !== e3(1, 0, 0, 0, 7 - c)) begin
        bad++; $display("FAIL full_collect c%0d got=%h exp=%h", c, {busy3, done3, pass3, yes3, tl3}, e3(1, 0, 0, 0, 7 - c));
      end
      tick();
    end
    total++;
    if ({busy3, done3, pass3, yes3, tl3} !== e3(0, 1, 1, 2, 0)) begin
      bad++; $display("FAIL full_done got=%h exp=%h", {busy3, done3, pass3, yes3, tl3}, e3(0, 1, 1, 2, 0));
    end
    tick();
    total++;
    if ({busy3, done3, pass3, yes3, tl3} !== e3(0, 0, 1, 2, 0)) begin
      bad++; $display("FAIL full_hold got=%h exp=%h", {busy3, done3, pass3, yes3, tl3}, e3(0, 0, 1, 2, 0));
    end
    vote3 = '0;
    tick();
  endtask

  task automatic test_sticky();
    start3 = 1; vote3 = '0;
    tick();
    start3 = 0;
    total++;
    if ({busy3, done3, pass3, yes3, tl3} !== e3(1, 0, 0, 0, 7)) begin
      bad++; $display("FAIL sticky_clear got=%h exp=%h", {busy3, done3, pass3, yes3, tl3}, e3(1, 0, 0, 0, 7));
    end
    tick();
    vote3 = 3'b001;
    tick();
    vote3 = 3'b000;
    for (int c = 0; c < 6; c++) tick();
    total++;
    if ({busy3, done3, pass3, yes3, tl3} !== e3(0, 1, 0, 1, 0)) begin
      bad++; $display("FAIL sticky_done got=%h exp=%h", {busy3, done3, pass3, yes3, tl3}, e3(0, 1, 0, 1, 0));
    end
    tick();
  endtask

  task automatic test_early_close();
    start3 = 1; vote3 = 3'b111;
    tick();
    start3 = 0;
    total++;
    if ({busy3, done3, pass3, yes3, tl3} !== e3(1, 0, 0, 0, 7)) begin
      bad++; $display("FAIL early_collect got=%h exp=%h", {busy3, done3, pass3, yes3, tl3}, e3(1, 0, 0, 0, 7));
    end
    tick();
    total++;
    if ({busy3, done3, pass3, yes3, tl3} !== e3(0, 1, 1, 3, 0)) begin
      bad++; $display("FAIL early_done got=%h exp=%h", {busy3, done3, pass3, yes3, tl3}, e3(0, 1, 1, 3, 0));
    end
    tick();
    total++;
    if ({busy3, done3, pass3, yes3, tl3} !== e3(0, 0, 1, 3, 0)) begin
      bad++; $display("FAIL early_idle got=%h exp=%h", {busy3, done3, pass3, yes3, tl3}, e3(0, 0, 1, 3, 0));
    end
    vote3 = '0;
  endtask

  task automatic test_ignored_start_and_reset();
    start3 = 1; vote3 = '0;
    tick();
    start3 = 0;
    tick();
    start3 = 1;
    tick();
    start3 = 0;
    total++;
    if ({busy3, done3, pass3, yes3, tl3} !== e3(1, 0, 0, 0, 5)) begin
      bad++; $display("FAIL ign_start got=%h exp=%h", {busy3, done3, pass3, yes3, tl3}, e3(1, 0, 0, 0, 5));
    end
    tick();
    total++;
    if (tl3 !== 16'd4) begin
      bad++; $display("FAIL ign_cyc4 got=%0d exp=4", tl3);
    end
    rst = 1; vote3 = 3'b111;
    tick();
    rst = 0; vote3 = '0;
    for (int c = 0; c < 10; c++) begin
      total++;
      if ({busy3, done3, pass3, yes3, tl3} !== e3(0, 0, 0, 0, 0)) begin
        bad++; $display("FAIL midrst c%0d got=%h exp=%h", c, {busy3, done3, pass3, yes3, tl3}, e3(0, 0, 0, 0, 0));
      end
      tick();
    end
    start3 = 1; vote3 = 3'b100;
    tick();
    start3 = 0;
    for (int c = 0; c < 8; c++) begin
      total++;
      if ({busy3, done3, tl3} !== {2'b10, 16'(7 - c)}) begin
        bad++; $display("FAIL rerun c%0d got=%h exp=%h", c, {busy3, done3, tl3}, {2'b10, 16'(7 - c)});
      end
      tick();
    end
    total++;
    if ({busy3, done3, pass3, yes3, tl3} !== e3(0, 1, 0, 1, 0)) begin
      bad++; $display("FAIL rerun_done got=%h exp=%h", {busy3, done3, pass3, yes3, tl3}, e3(0, 1, 0, 1, 0));
    end
    vote3 = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    // start held high: early close at k+1, result at k+2, re-accept at k+3
    start3 = 1; vote3 = 3'b111;
    tick();
    tick();
    tick();
    total++;
    if ({busy3, done3} !== 2'b00) begin
      bad++; $display("FAIL b2b_idle got=%b exp=00", {busy3, done3});
    end
    tick();
    start3 = 0;
    total++;
    if ({busy3, done3, pass3, yes3, tl3} !== e3(1, 0, 0, 0, 7)) begin
      bad++; $display("FAIL b2b_reaccept got=%h exp=%h", {busy3, done3, pass3, yes3, tl3}, e3(1, 0, 0, 0, 7));
    end
    tick();
    tick();
    vote3 = '0;
  endtask

  task automatic test_unanimous();
    start5 = 1; vote5 = 5'b11110;
    tick();
    start5 = 0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if ({busy5, done5, pass5, yes5, tl5} !== e5(1, 0, 0, 0, 3 - c)) begin
        bad++; $display("FAIL unan_collect c%0d got=%h exp=%h", c, {busy5, done5, pass5, yes5, tl5}, e5(1, 0, 0, 0, 3 - c));
      end
      tick();
    end
    total++;
    if ({busy5, done5, pass5, yes5, tl5} !== e5(0, 1, 0, 4, 0)) begin
      bad++; $display("FAIL unan_fail got=%h exp=%h", {busy5, done5, pass5, yes5, tl5}, e5(0, 1, 0, 4, 0));
    end
    tick();
    start5 = 1; vote5 = 5'b11111;
    tick();
    start5 = 0;
    total++;
    if ({busy5, done5, pass5, yes5, tl5} !== e5(1, 0, 0, 0, 3)) begin
      bad++; $display("FAIL unan_start got=%h exp=%h", {busy5, done5, pass5, yes5, tl5}, e5(1, 0, 0, 0, 3));
    end
    tick();
    total++;
    if ({busy5, done5, pass5, yes5, tl5} !== e5(0, 1, 1, 5, 0)) begin
      bad++; $display("FAIL unan_pass got=%h exp=%h", {busy5, done5, pass5, yes5, tl5}, e5(0, 1, 1, 5, 0));
    end
    vote5 = '0;
    tick();
  endtask

  initial begin
    rst = 0; start3 = 0; vote3 = '0; start5 = 0; vote5 = '0;
    test_reset();
    test_full_window();
    test_sticky();
    test_early_close();
    test_ignored_start_and_reset();
    test_back_to_back();
    test_unanimous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
